// File: rtl/uart_two_byte_top.sv
// Board bring-up smoke test: after reset, send two fixed bytes over an
// 8N1 UART line, then idle forever. Two sticky LEDs mark each byte done.
//
// Handshake between the sequencer and the transmitter (valid/accept):
//   valid_i is a level request. A byte is accepted on any rising edge where
//   valid_i=1 and the transmitter is idle (idle_o=1). data_i is sampled on
//   that edge only. While the transmitter is busy, valid_i is ignored.
//   done_o pulses for exactly one cycle, starting at the edge that ends
//   the stop bit, which is also the edge where the transmitter becomes idle.

// 8N1 transmitter, LSB first, ClocksPerBaud cycles per bit.
module uart_tx #(
  parameter int ClocksPerBaud = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       tx_o,
  output logic       done_o,
  output logic       idle_o
);

  // The baud counter needs at least one bit so that ClocksPerBaud=1 works.
  localparam int CntW = (ClocksPerBaud > 1) ? $clog2(ClocksPerBaud) : 1;
  localparam logic [CntW-1:0] BaudLast = CntW'(ClocksPerBaud - 1);
  localparam logic [3:0] LastBit = 4'd9;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;

  tx_state_t       tx_state_q;
  logic [CntW-1:0] baud_q;
  logic [3:0]      bit_q;
  logic [8:0]      shift_q;
  logic            tx_q;
  logic            done_q;

  assign tx_o   = tx_q;
  assign done_o = done_q;
  assign idle_o = (tx_state_q == IDLE);

  // Frame sequencing: start bit on accept, then shift out data and stop bit.
  // shift_q holds {stop, d7..d0}; each bit boundary moves the next one out.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_state_q <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '1;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (tx_state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (valid_i) begin
            tx_state_q <= SEND;
            shift_q    <= {1'b1, data_i};
            tx_q       <= 1'b0;
            baud_q     <= '0;
            bit_q      <= '0;
          end
        end
        SEND: begin
          if (baud_q == BaudLast) begin
            baud_q <= '0;
            if (bit_q == LastBit) begin
              tx_state_q <= IDLE;
              bit_q      <= '0;
              tx_q       <= 1'b1;
              done_q     <= 1'b1;
            end else begin
              bit_q   <= bit_q + 4'd1;
              tx_q    <= shift_q[0];
              shift_q <= {1'b1, shift_q[8:1]};
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          tx_state_q <= IDLE;
          tx_q       <= 1'b1;
        end
      endcase
    end
  end

endmodule

// Top level: sequencer FSM feeding the transmitter two fixed bytes.
module uart_two_byte_top #(
  parameter int         ClocksPerBaud = 2,
  parameter logic [7:0] FirstByte     = 8'h48,
  parameter logic [7:0] SecondByte    = 8'h69
) (
  input  logic clk,
  input  logic rst,
  output logic tx_out,
  output logic led_left_out,
  output logic led_center_out
);

  typedef enum logic [2:0] {
    SEND_FIRST  = 3'd0,
    WAIT_FIRST  = 3'd1,
    SEND_SECOND = 3'd2,
    WAIT_SECOND = 3'd3,
    DONE        = 3'd4
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic       led_left_q;
  logic       led_center_q;
  logic [7:0] tx_byte;
  logic       tx_byte_valid;
  logic       tx_byte_done;
  logic       tx_idle;

  assign tx_byte = ((state_q == SEND_FIRST) || (state_q == WAIT_FIRST)) ?
                   FirstByte : SecondByte;
  assign tx_byte_valid  = (state_q == SEND_FIRST) || (state_q == SEND_SECOND);
  assign led_left_out   = led_left_q;
  assign led_center_out = led_center_q;

  uart_tx #(
    .ClocksPerBaud(ClocksPerBaud)
  ) transmitter (
    .clk_i  (clk),
    .rst_i  (rst),
    .data_i (tx_byte),
    .valid_i(tx_byte_valid),
    .tx_o   (tx_out),
    .done_o (tx_byte_done),
    .idle_o (tx_idle)
  );

  // Next state: advance on accept (send states) or on the done pulse (wait states).
  always_comb begin
    state_d = state_q;
    case (state_q)
      SEND_FIRST:  if (tx_idle)      state_d = WAIT_FIRST;
      WAIT_FIRST:  if (tx_byte_done) state_d = SEND_SECOND;
      SEND_SECOND: if (tx_idle)      state_d = WAIT_SECOND;
      WAIT_SECOND: if (tx_byte_done) state_d = DONE;
      DONE:                          state_d = DONE;
      default:                       state_d = SEND_FIRST;
    endcase
  end

  // State register plus sticky LEDs, set on the edge each byte is reported done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= SEND_FIRST;
      led_left_q   <= 1'b0;
      led_center_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == WAIT_FIRST) && tx_byte_done) begin
        led_left_q <= 1'b1;
      end
      if ((state_q == WAIT_SECOND) && tx_byte_done) begin
        led_center_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_two_byte_top.sv
// Bench for uart_two_byte_top: three instances (B=1, 2, 4) sharing a clock,
// each with its own reset. Expected line bits are queued when a frame is
// expected and popped at each bit midpoint.
module tb_uart_two_byte_top;

  localparam logic [7:0] FIRST_B  = 8'h48;
  localparam logic [7:0] SECOND_B = 8'h69;
  localparam logic [2:0] ST_SEND_FIRST = 3'd0;
  localparam logic [2:0] ST_DONE       = 3'd4;

  logic clk;
  logic rst_b1, rst_b2, rst_b4;
  logic tx_b1, tx_b2, tx_b4;
  logic ll_b1, ll_b2, ll_b4;
  logic lc_b1, lc_b2, lc_b4;

  int checks;
  int failures;
  int edge_n;
  int sel;
  logic [0:0] exp_q[$];

  logic       tx_m, ll_m, lc_m, done_m;
  logic [2:0] st_m;

  // Clock and reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst_b1 = 1'b1;
    rst_b2 = 1'b1;
    rst_b4 = 1'b1;
  end

  uart_two_byte_top #(.ClocksPerBaud(1)) dut_b1 (
    .clk(clk), .rst(rst_b1), .tx_out(tx_b1),
    .led_left_out(ll_b1), .led_center_out(lc_b1));
  uart_two_byte_top #(.ClocksPerBaud(2)) dut_b2 (
    .clk(clk), .rst(rst_b2), .tx_out(tx_b2),
    .led_left_out(ll_b2), .led_center_out(lc_b2));
  uart_two_byte_top #(.ClocksPerBaud(4)) dut_b4 (
    .clk(clk), .rst(rst_b4), .tx_out(tx_b4),
    .led_left_out(ll_b4), .led_center_out(lc_b4));

  // Observation mux for the instance under test
  always_comb begin
    tx_m = 1'b1; ll_m = 1'b0; lc_m = 1'b0; done_m = 1'b0; st_m = 3'd0;
    case (sel)
      1: begin
        tx_m = tx_b1; ll_m = ll_b1; lc_m = lc_b1;
        done_m = dut_b1.tx_byte_done; st_m = dut_b1.state_q;
      end
      2: begin
        tx_m = tx_b2; ll_m = ll_b2; lc_m = lc_b2;
        done_m = dut_b2.tx_byte_done; st_m = dut_b2.state_q;
      end
      default: begin
        tx_m = tx_b4; ll_m = ll_b4; lc_m = lc_b4;
        done_m = dut_b4.tx_byte_done; st_m = dut_b4.state_q;
      end
    endcase
  end

  // Driver tasks: always return positioned at the falling edge after edge_n.
  task automatic tick();
    @(posedge clk);
    edge_n++;
    @(negedge clk);
  endtask

  task automatic goto_edge(input int n);
    while (edge_n < n) tick();
  endtask

  task automatic set_rst(input logic v);
    case (sel)
      1:       rst_b1 = v;
      2:       rst_b2 = v;
      default: rst_b4 = v;
    endcase
  endtask

  task automatic release_reset();
    set_rst(1'b0);
    edge_n = 0;
  endtask

  // Frame decode: queue start, 8 data bits LSB first, stop; sample midpoints.
  task automatic test_frame(input int start_edge, input logic [7:0] byte_v,
                            input int b, input string tag);
    logic [0:0] e;
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(byte_v[i]);
    exp_q.push_back(1'b1);
    for (int k = 0; k < 10; k++) begin
      goto_edge(start_edge + k * b + b / 2);
      e = exp_q.pop_front();
      checks++;
      if (tx_m !== e) begin
        failures++;
        $display("FAIL %s_bit%0d: tx_out got %b expected %b", tag, k, tx_m, e);
      end
    end
  endtask

  task automatic test_reset(input int s);
    sel = s;
    set_rst(1'b1);
    repeat (4) tick();
    checks++;
    if ({tx_m, ll_m, lc_m} !== 3'b100) begin
      failures++;
      $display("FAIL reset_outputs_b%0d: got tx/ll/lc=%b expected 100", s, {tx_m, ll_m, lc_m});
    end
    checks++;
    if (st_m !== ST_SEND_FIRST) begin
      failures++;
      $display("FAIL reset_state_b%0d: got %0d expected %0d", s, st_m, ST_SEND_FIRST);
    end
    release_reset();
  endtask

  task automatic test_first_frame_b2();
    test_frame(1, FIRST_B, 2, "b2_first");
    goto_edge(21);
    checks++;
    if ({done_m, ll_m, tx_m} !== 3'b101) begin
      failures++;
      $display("FAIL b2_done1_edge21: got done/ll/tx=%b expected 101", {done_m, ll_m, tx_m});
    end
    goto_edge(22);
    checks++;
    if ({done_m, ll_m, lc_m, tx_m} !== 4'b0101) begin
      failures++;
      $display("FAIL b2_led_left_edge22: got done/ll/lc/tx=%b expected 0101", {done_m, ll_m, lc_m, tx_m});
    end
  endtask

  task automatic test_second_frame_b2();
    test_frame(23, SECOND_B, 2, "b2_second");
    goto_edge(43);
    checks++;
    if ({done_m, lc_m} !== 2'b10) begin
      failures++;
      $display("FAIL b2_done2_edge43: got done/lc=%b expected 10", {done_m, lc_m});
    end
    goto_edge(44);
    checks++;
    if ({ll_m, lc_m} !== 2'b11) begin
      failures++;
      $display("FAIL b2_led_center_edge44: got ll/lc=%b expected 11", {ll_m, lc_m});
    end
    checks++;
    if (st_m !== ST_DONE) begin
      failures++;
      $display("FAIL b2_state_done: got %0d expected %0d", st_m, ST_DONE);
    end
  endtask

  task automatic test_idle_b2();
    int bad_tx;
    int pulses;
    int bad_led;
    bad_tx = 0; pulses = 0; bad_led = 0;
    while (edge_n < 256) begin
      tick();
      if (tx_m !== 1'b1) bad_tx++;
      if (done_m !== 1'b0) pulses++;
      if ({ll_m, lc_m} !== 2'b11) bad_led++;
    end
    checks++;
    if (bad_tx != 0) begin
      failures++;
      $display("FAIL idle_tx_high: got %0d low cycles expected 0", bad_tx);
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL idle_no_done: got %0d pulses expected 0", pulses);
    end
    checks++;
    if (bad_led != 0) begin
      failures++;
      $display("FAIL idle_leds_hold: got %0d bad cycles expected 0", bad_led);
    end
  endtask

  // Abort the first frame mid-byte (data bit 2 = 0, data bit 3 = 1), then
  // confirm a complete fresh 0x48 frame from edge 1.
  task automatic test_mid_reset_b2();
    logic [0:0] pre_exp;
    for (int d = 2; d <= 3; d++) begin
      sel = 2;
      set_rst(1'b1);
      repeat (2) tick();
      release_reset();
      goto_edge(1 + (d + 1) * 2);
      pre_exp = FIRST_B[d];
      checks++;
      if (tx_m !== pre_exp) begin
        failures++;
        $display("FAIL midrst_pre_d%0d: tx_out got %b expected %b", d, tx_m, pre_exp);
      end
      #2;
      set_rst(1'b1);
      #1;
      checks++;
      if ({tx_m, ll_m, lc_m, st_m} !== {3'b100, ST_SEND_FIRST}) begin
        failures++;
        $display("FAIL midrst_async_d%0d: got tx/ll/lc/st=%b expected 100000", d, {tx_m, ll_m, lc_m, st_m});
      end
      @(negedge clk);
      release_reset();
      test_frame(1, FIRST_B, 2, $sformatf("midrst_restart_d%0d", d));
    end
  endtask

  task automatic test_other_baud(input int s, input int b);
    sel = s;
    set_rst(1'b1);
    repeat (2) tick();
    release_reset();
    test_frame(1, FIRST_B, b, $sformatf("b%0d_first", b));
    test_frame(3 + 10 * b, SECOND_B, b, $sformatf("b%0d_second", b));
    goto_edge(3 + 20 * b);
    checks++;
    if ({ll_m, lc_m} !== 2'b10) begin
      failures++;
      $display("FAIL b%0d_led_before: got ll/lc=%b expected 10", b, {ll_m, lc_m});
    end
    goto_edge(4 + 20 * b);
    checks++;
    if ({ll_m, lc_m} !== 2'b11) begin
      failures++;
      $display("FAIL b%0d_led_center_rise: got ll/lc=%b expected 11", b, {ll_m, lc_m});
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    edge_n = 0;
    sel = 2;
    @(negedge clk);
    test_reset(2);
    test_first_frame_b2();
    test_second_frame_b2();
    test_idle_b2();
    test_mid_reset_b2();
    test_reset(1);
    test_other_baud(1, 1);
    test_reset(4);
    test_other_baud(4, 4);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
